// File: rtl/inference_sequencer_if.sv
// inference_sequencer_if
//   Bundles the camera sync inputs, the gated sync outputs, the layer done
//   pulses, the network result and the status outputs of inference_sequencer.
//   master: the environment (camera, network, host); slave: the sequencer.
//   Signals: en, clear_err, VSYNC, HSYNC, layer_done, net_result (to sequencer);
//            vsync_out, hsync_out, result, result_valid, busy, frame_err,
//            timeout_err, frames_dropped (from sequencer).
interface inference_sequencer_if #(
    parameter int number_of_layers = 5,
    parameter int result_width     = 4
);
    logic                          en;
    logic                          clear_err;
    logic                          VSYNC;
    logic                          HSYNC;
    logic [number_of_layers-2:0]   layer_done;
    logic [result_width-1:0]       net_result;
    logic                          vsync_out;
    logic                          hsync_out;
    logic [result_width-1:0]       result;
    logic                          result_valid;
    logic                          busy;
    logic                          frame_err;
    logic                          timeout_err;
    logic [7:0]                    frames_dropped;

    modport master (
        output en, clear_err, VSYNC, HSYNC, layer_done, net_result,
        input  vsync_out, hsync_out, result, result_valid, busy,
               frame_err, timeout_err, frames_dropped
    );

    modport slave (
        input  en, clear_err, VSYNC, HSYNC, layer_done, net_result,
        output vsync_out, hsync_out, result, result_valid, busy,
               frame_err, timeout_err, frames_dropped
    );
endinterface

// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Frame-level controller between the camera and the streaming network.
//   Admits one frame at a time by gating VSYNC/HSYNC, checks the pixel count,
//   tracks the per-layer done pulses in order under a watchdog and publishes
//   each classification once with a one-cycle valid strobe.
//   Ports: clk, rst_n (async, active low), bus (inference_sequencer_if.slave).
module inference_sequencer #(
    parameter int number_of_layers = 5,
    parameter int pixels_per_frame = 4096,
    parameter int timeout_cycles   = 1048576,
    parameter int result_width     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inference_sequencer_if.slave bus
);
    localparam int NDONE = number_of_layers - 1;
    localparam int PIX_W = $clog2(pixels_per_frame + 1);
    localparam int WD_W  = $clog2(timeout_cycles);
    localparam int K_W   = (NDONE > 1) ? $clog2(NDONE) : 1;
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(pixels_per_frame);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(timeout_cycles - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NDONE - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_COMPUTE, S_RESULT} state_t;
    state_t r_state, w_next;

    logic                    r_vs_q, r_hs_q, r_vs_prev;
    logic [PIX_W-1:0]        r_pix;
    logic                    r_ovf;
    logic [K_W-1:0]          r_k;
    logic [WD_W-1:0]         r_wd;
    logic                    r_pub;
    logic                    r_vsync_out, r_hsync_out;
    logic [result_width-1:0] r_result;
    logic                    r_valid, r_ferr, r_terr;
    logic [7:0]              r_drop;

    logic             w_fall, w_rise, w_full, w_hit, w_stray, w_pass_vs;
    logic             w_cap_start, w_cmp_start, w_ferr_set, w_terr_set;
    logic [NDONE-1:0] w_kmask;

    assign w_fall    = r_vs_prev & ~r_vs_q;
    assign w_rise    = ~r_vs_prev & r_vs_q;
    assign w_full    = (r_pix == PIX_FULL);
    assign w_kmask   = NDONE'(1) << r_k;
    assign w_hit     = bus.layer_done[r_k];
    assign w_stray   = |(bus.layer_done & ~w_kmask);
    // The falling edge itself is passed through so the stream block sees the
    // whole frame, including its start.
    assign w_pass_vs = (r_state == S_CAPTURE) || (r_state == S_WAIT_VS && w_fall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cap_start = 1'b0;
        w_cmp_start = 1'b0;
        w_ferr_set  = 1'b0;
        w_terr_set  = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.en) w_next = S_WAIT_VS;
            S_WAIT_VS: begin
                if (w_fall) begin
                    w_next      = S_CAPTURE;
                    w_cap_start = 1'b1;
                end else if (!bus.en) begin
                    w_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (w_rise) begin
                    if (w_full && !r_ovf) begin
                        w_next      = S_COMPUTE;
                        w_cmp_start = 1'b1;
                    end else begin
                        w_ferr_set = 1'b1;
                        w_next     = S_WAIT_VS;
                    end
                end
            end
            S_COMPUTE: begin
                w_ferr_set = w_stray;
                // Accepting the last done pulse wins over a watchdog expiry in the same cycle.
                if (w_hit && r_k == K_LAST) begin
                    w_next = S_RESULT;
                end else if (r_wd == WD_LAST) begin
                    w_terr_set = 1'b1;
                    w_next     = S_WAIT_VS;
                end
            end
            S_RESULT:  w_next = bus.en ? S_WAIT_VS : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Sync history resets to "active", so a frame already under way at
            // reset release produces no falling edge and is never admitted.
            r_vs_q      <= 1'b0;
            r_hs_q      <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_pix       <= '0;
            r_ovf       <= 1'b0;
            r_k         <= '0;
            r_wd        <= '0;
            r_pub       <= 1'b0;
            r_vsync_out <= 1'b1;
            r_hsync_out <= 1'b0;
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_terr      <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_vs_q    <= bus.VSYNC;
            r_hs_q    <= bus.HSYNC;
            r_vs_prev <= r_vs_q;

            if (w_cap_start) begin
                r_pix <= '0;
                r_ovf <= 1'b0;
            end else if (r_state == S_CAPTURE && r_hs_q) begin
                if (w_full) r_ovf <= 1'b1;
                else        r_pix <= r_pix + 1'b1;
            end

            if (w_cmp_start) begin
                r_k  <= '0;
                r_wd <= '0;
            end else if (r_state == S_COMPUTE) begin
                r_wd <= r_wd + 1'b1;
                if (w_hit) r_k <= r_k + 1'b1;
            end

            r_vsync_out <= w_pass_vs ? r_vs_q : 1'b1;
            r_hsync_out <= (r_state == S_CAPTURE) && r_hs_q && !w_full;

            // One extra cycle after RESULT gives output_layer time to settle
            // before net_result is sampled.
            r_pub   <= (r_state == S_RESULT);
            r_valid <= r_pub;
            if (r_pub) r_result <= bus.net_result;

            if (bus.clear_err)       r_ferr <= 1'b0;
            else if (w_ferr_set)     r_ferr <= 1'b1;
            if (bus.clear_err)       r_terr <= 1'b0;
            else if (w_terr_set)     r_terr <= 1'b1;

            if (bus.clear_err)
                r_drop <= '0;
            else if (w_fall && (r_state == S_COMPUTE || r_state == S_RESULT) && r_drop != 8'hFF)
                r_drop <= r_drop + 1'b1;
        end
    end

    assign bus.vsync_out      = r_vsync_out;
    assign bus.hsync_out      = r_hsync_out;
    assign bus.result         = r_result;
    assign bus.result_valid   = r_valid;
    assign bus.busy           = (r_state == S_CAPTURE) || (r_state == S_COMPUTE);
    assign bus.frame_err      = r_ferr;
    assign bus.timeout_err    = r_terr;
    assign bus.frames_dropped = r_drop;
endmodule

// File: tb/tb_inference_sequencer.sv
module tb_inference_sequencer;
    localparam int NL  = 5;
    localparam int PPF = 64;
    localparam int TO  = 64;
    localparam int RW  = 4;
    localparam int ND  = NL - 1;

    localparam int P_OFF = 0, P_ARM = 1, P_FRM = 2, P_NET = 3, P_PUB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inference_sequencer_if #(.number_of_layers(NL), .result_width(RW)) ifc();

    inference_sequencer #(
        .number_of_layers(NL), .pixels_per_frame(PPF),
        .timeout_cycles(TO), .result_width(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    int vectors = 0, miscompares = 0;
    int hs_seen = 0, val_seen = 0, cyc_no = 0;
    int cur_nr = 0, clr_pct = 0;
    bit nr_rand = 1'b0;

    // ---------------- behavioural model ----------------
    int          ph, pix, nxt, ccyc, e_drop;
    bit          m_vq, m_vp, m_hq, pub_pend;
    bit          e_vs, e_hs, e_val, e_busy, e_ferr, e_terr;
    logic [RW-1:0] e_res;

    task automatic model_reset();
        ph = P_OFF; pix = 0; nxt = 0; ccyc = 0; e_drop = 0;
        m_vq = 0; m_vp = 0; m_hq = 0; pub_pend = 0;
        e_vs = 1; e_hs = 0; e_val = 0; e_busy = 0; e_ferr = 0; e_terr = 0; e_res = '0;
    endtask

    task automatic model_step(input bit v, input bit h, input bit en, input bit clr,
                              input logic [ND-1:0] ld, input logic [RW-1:0] nr);
        bit fall, rise, fset, tset;
        fall = m_vp && !m_vq;
        rise = !m_vp && m_vq;
        fset = 0; tset = 0;
        e_vs  = (ph == P_FRM || (ph == P_ARM && fall)) ? m_vq : 1'b1;
        e_hs  = (ph == P_FRM) && m_hq && (pix < PPF);
        e_val = pub_pend;
        if (pub_pend) e_res = nr;
        pub_pend = (ph == P_PUB);
        if (fall && (ph == P_NET || ph == P_PUB) && e_drop < 255) e_drop++;
        case (ph)
            P_OFF: if (en) ph = P_ARM;
            P_ARM: begin
                if (fall) begin ph = P_FRM; pix = 0; end
                else if (!en) ph = P_OFF;
            end
            P_FRM: begin
                if (rise) begin
                    if (pix == PPF) begin ph = P_NET; nxt = 0; ccyc = 0; end
                    else begin fset = 1; ph = P_ARM; end
                end else if (m_hq) pix++;
            end
            P_NET: begin
                if ((ld & ~(ND'(1) << nxt)) != 0) fset = 1;
                if (ld[nxt] && nxt == ND - 1) ph = P_PUB;
                else if (ccyc == TO - 1) begin tset = 1; ph = P_ARM; end
                else if (ld[nxt]) nxt++;
                ccyc++;
            end
            default: ph = en ? P_ARM : P_OFF;
        endcase
        if (clr) begin e_ferr = 0; e_terr = 0; e_drop = 0; end
        else begin
            if (fset) e_ferr = 1;
            if (tset) e_terr = 1;
        end
        m_vp = m_vq; m_vq = v; m_hq = h;
        e_busy = (ph == P_FRM || ph == P_NET);
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [RW+13:0] act, exp;
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(ifc.VSYNC, ifc.HSYNC, ifc.en, ifc.clear_err, ifc.layer_done, ifc.net_result);
            #2;
            cyc_no++;
            act = {ifc.vsync_out, ifc.hsync_out, ifc.result, ifc.result_valid, ifc.busy,
                   ifc.frame_err, ifc.timeout_err, ifc.frames_dropped};
            exp = {e_vs, e_hs, e_res, e_val, e_busy, e_ferr, e_terr, e_drop[7:0]};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got %h expected %h", cyc_no, act, exp);
            end
            if (ifc.hsync_out === 1'b1)    hs_seen++;
            if (ifc.result_valid === 1'b1) val_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit h, input logic [ND-1:0] ld, input bit clr = 1'b0);
        @(negedge clk);
        ifc.VSYNC      = v;
        ifc.HSYNC      = h;
        ifc.layer_done = ld;
        ifc.clear_err  = clr || ($urandom_range(0, 99) < clr_pct);
        ifc.net_result = nr_rand ? RW'($urandom) : RW'(cur_nr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 0, '0);
    endtask

    task automatic send_frame(input int npix, input int maxgap);
        repeat (3) drive(1, 0, '0);
        repeat (2) drive(0, 0, '0);
        for (int i = 0; i < npix; i++) begin
            repeat ($urandom_range(0, maxgap)) drive(0, 0, '0);
            drive(0, 1, '0);
        end
        repeat (2) drive(0, 0, '0);
        repeat (3) drive(1, 0, '0);
    endtask

    // Returns the number of cycles until result_valid, 0 if none within the bound.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, '0);
            if (ifc.result_valid === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic good_dones(output int n);
        drive(1, 0, ND'(1)); drive(1, 0, '0);
        drive(1, 0, ND'(2)); drive(1, 0, '0);
        drive(1, 0, ND'(4)); drive(1, 0, '0);
        drive(1, 0, ND'(8));
        wait_valid(n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, vb, hb, kind, npix, mode;
        ifc.en = 0; ifc.clear_err = 0; ifc.VSYNC = 1; ifc.HSYNC = 0;
        ifc.layer_done = '0; ifc.net_result = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, '0);
        chk("rst_vsync", ifc.vsync_out, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_result", ifc.result, 0);
        chk("rst_dropped", ifc.frames_dropped, 0);
        ifc.en = 1;

        // nominal frame
        cur_nr = 3; vb = val_seen;
        send_frame(PPF, 2);
        good_dones(n);
        chk("nom_latency", n, 3);
        chk("nom_result", ifc.result, 3);
        chk("nom_ferr", ifc.frame_err, 0);
        chk("nom_terr", ifc.timeout_err, 0);
        idle(3);
        chk("nom_strobes", val_seen - vb, 1);

        // short frame, then recovery
        vb = val_seen;
        send_frame(PPF - 1, 1);
        idle(20);
        chk("short_ferr", ifc.frame_err, 1);
        chk("short_busy", ifc.busy, 0);
        chk("short_nostrobe", val_seen - vb, 0);
        drive(1, 0, '0, 1'b1); drive(1, 0, '0);
        chk("short_clr", ifc.frame_err, 0);
        send_frame(PPF, 0);
        good_dones(n);
        chk("short_recover", n, 3);

        // overflow
        hb = hs_seen;
        send_frame(PPF + 4, 0);
        idle(2);
        chk("ovf_hs_passed", hs_seen - hb, PPF);
        chk("ovf_ferr", ifc.frame_err, 1);
        drive(1, 0, '0, 1'b1);

        // dropped frames during compute
        send_frame(PPF, 1);
        drive(1, 0, ND'(1));
        repeat (3) begin drive(0, 0, '0); drive(0, 0, '0); drive(1, 0, '0); drive(1, 0, '0); end
        drive(1, 0, ND'(2)); drive(1, 0, ND'(4)); drive(1, 0, ND'(8));
        wait_valid(n);
        chk("drop_valid", n, 3);
        chk("drop_count", ifc.frames_dropped, 3);
        drive(1, 0, '0, 1'b1); drive(1, 0, '0);
        chk("drop_clr", ifc.frames_dropped, 0);

        // watchdog
        cur_nr = 9; vb = val_seen;
        send_frame(PPF, 0);
        drive(1, 0, ND'(1)); drive(1, 0, ND'(2)); drive(1, 0, ND'(4));
        idle(70);
        chk("wd_terr", ifc.timeout_err, 1);
        chk("wd_result", ifc.result, 3);
        chk("wd_busy", ifc.busy, 0);
        chk("wd_nostrobe", val_seen - vb, 0);
        drive(1, 0, '0, 1'b1);

        // out-of-order done pulse
        cur_nr = 5;
        send_frame(PPF, 0);
        drive(1, 0, ND'(1)); drive(1, 0, '0);
        drive(1, 0, ND'(4)); drive(1, 0, '0);
        drive(1, 0, ND'(2)); drive(1, 0, '0);
        drive(1, 0, ND'(4)); drive(1, 0, '0);
        drive(1, 0, ND'(8));
        wait_valid(n);
        chk("ord_valid", n, 3);
        chk("ord_ferr", ifc.frame_err, 1);
        chk("ord_result", ifc.result, 5);

        // reset in the middle of capture
        idle(2);
        drive(0, 0, '0); drive(0, 0, '0);
        repeat (10) drive(0, 1, '0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vsync", ifc.vsync_out, 1);
        chk("arst_hsync", ifc.hsync_out, 0);
        chk("arst_busy", ifc.busy, 0);
        chk("arst_result", ifc.result, 0);
        chk("arst_ferr", ifc.frame_err, 0);
        repeat (2) drive(0, 1, '0);
        rst_n = 1'b1;
        repeat (40) drive(0, 1, '0);
        drive(0, 0, '0);
        idle(3);
        chk("arst_partial_ignored", ifc.busy, 0);
        send_frame(PPF, 1);
        good_dones(n);
        chk("arst_recover", n, 3);
        chk("arst_result2", ifc.result, 5);

        // randomized episodes, checked by the model every cycle
        nr_rand = 1'b1; clr_pct = 3;
        for (int ep = 0; ep < 60; ep++) begin
            if ($urandom_range(0, 9) == 0) begin
                ifc.en = 0; idle($urandom_range(1, 4)); ifc.en = 1;
            end
            kind = $urandom_range(0, 5);
            npix = (kind == 0) ? PPF - 1 : (kind == 1) ? PPF + $urandom_range(1, 3) : PPF;
            send_frame(npix, $urandom_range(0, 2));
            mode = $urandom_range(0, 6);
            if (mode == 3) ifc.en = 0;
            for (int b = 0; b < ND; b++) begin
                if (mode == 2 && b == ND - 1) break;
                if (mode == 1 && b == 1) drive(1, 0, ND'($urandom));
                if (mode == 4 && b == 2) begin drive(0, 0, '0); drive(1, 0, '0); end
                drive(1, 0, ND'(1 << b));
                repeat ($urandom_range(0, 3)) drive(1, 0, '0);
            end
            idle(mode == 2 ? 70 : 6);
            ifc.en = 1;
        end
        clr_pct = 0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Frame-level controller between the camera sync inputs and the streaming network. It admits one frame at a time into the pixel stream block by gating VSYNC/HSYNC. It checks that exactly one full frame of pixels arrives, tracks the per-layer done pulses in order, and applies a watchdog. It publishes each classification exactly once with a valid strobe; frames that arrive while an inference is in flight are dropped and counted.

## Interface
- `number_of_layers`, default 5: network depth; the block tracks `number_of_layers-1` done pulses.
- `pixels_per_frame`, default 4096: active pixels per frame (64x64).
- `timeout_cycles`, default 1048576: COMPUTE watchdog limit, in cycles.
- `result_width`, default 4: width of the class result.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: allows new frames to be admitted.
- `clear_err`, in, 1: single-cycle pulse; clears the sticky error flags and `frames_dropped`.
- `VSYNC`, in, 1: camera VSYNC; high means vertical blanking.
- `HSYNC`, in, 1: camera HSYNC; high means an active pixel this cycle.
- `vsync_out`, out, 1: gated VSYNC to the pixel stream block.
- `hsync_out`, out, 1: gated HSYNC to the pixel stream block.
- `layer_done`, in, `number_of_layers-1`: done pulses; bit k is layer k (bit 0 is the stream block, the top bit is the last select block).
- `net_result`, in, `result_width`: network output_layer result.
- `result`, out, `result_width`: latched classification.
- `result_valid`, out, 1: one-cycle strobe when `result` updates.
- `busy`, out, 1: high in CAPTURE or COMPUTE.
- `frame_err`, out, 1: sticky; set by a bad pixel count or an out-of-order done pulse.
- `timeout_err`, out, 1: sticky; set when the watchdog expires.
- `frames_dropped`, out, 8: saturating count of frames not admitted.

## Operation
- Input register: `VSYNC` and `HSYNC` are registered once into `vs_q` and `hs_q`. Edges are detected on `vs_q` against its previous value. Frame start is a falling edge of `vs_q`; frame end is a rising edge.
- States: IDLE, WAIT_VS, CAPTURE, COMPUTE, RESULT.
- IDLE: if `en`=1, go to WAIT_VS.
- WAIT_VS:
  - On frame start, go to CAPTURE and clear the pixel count.
  - If `en`=0, go to IDLE.
- CAPTURE:
  - `vsync_out`/`hsync_out` follow `vs_q`/`hs_q`.
  - Each cycle with `hs_q`=1 increments the pixel count.
  - Once the count equals `pixels_per_frame`, further `hs_q` highs are masked (`hsync_out`=0) and set an overflow flag.
  - On frame end with count == `pixels_per_frame` and no overflow, go to COMPUTE.
  - On frame end otherwise, set `frame_err` and go to WAIT_VS.
- COMPUTE:
  - An expected index `k` starts at 0 and the watchdog starts at 0.
  - `layer_done[k]`=1 advances `k`.
  - Any other `layer_done` bit high sets `frame_err` and is otherwise ignored.
  - After the top bit is accepted, go to RESULT.
  - If the watchdog reaches `timeout_cycles-1`, set `timeout_err` and go to WAIT_VS; `result` is unchanged.
- RESULT: lasts one cycle (lets output_layer register its result). On exit, `result` <= `net_result` and `result_valid`=1 for one cycle. Next state is WAIT_VS if `en`=1, else IDLE.
- Outside CAPTURE, gating holds `vsync_out`=1 and `hsync_out`=0, so the network sees continuous blanking.
- Dropped frames: a frame start seen in COMPUTE or RESULT increments `frames_dropped`, saturating at 255.
- `en` falling during CAPTURE or COMPUTE does not abort the frame. The current inference completes, then the block goes to IDLE.
- `clear_err` has priority over a set in the same cycle: the flag clears.

## Timing
- Reset values:
  - state IDLE;
  - `vsync_out`=1, `hsync_out`=0;
  - `result`=0, `result_valid`=0, `busy`=0;
  - `frame_err`=0, `timeout_err`=0, `frames_dropped`=0;
  - all counters 0.
- Reset asserted mid-frame or mid-compute returns immediately to the reset values. The next admitted frame is the first full frame after reset: its falling edge must be seen in WAIT_VS.
- Sync path latency: `VSYNC`/`HSYNC` to `vsync_out`/`hsync_out` is 2 cycles (input register plus output register).
- Result latency: if the last `layer_done` bit is high at edge t, then `result_valid`=1 and `result` updates in the cycle after edge t+2.
- `busy` rises the cycle after the frame-start edge is detected. It falls when RESULT is entered, on timeout, or on frame error.
- The watchdog counts COMPUTE cycles only and is cleared on entry to COMPUTE.
- Widths: the pixel counter is `$clog2(pixels_per_frame+1)` bits; the watchdog is `$clog2(timeout_cycles)` bits.

## Test plan
- Nominal frame: `en`=1, one frame of 4096 `HSYNC`-high cycles, then done pulses for bits 0..3 with `net_result`=3 → single `result_valid` strobe, `result`=3, both error flags 0.
- Short frame: frame with 4095 pixels → `frame_err`=1, no `result_valid`, state returns to WAIT_VS, and a following good frame yields `result_valid`.
- Overflow: 4100 pixels in one frame → `hsync_out` low for the last 4 pixels, `frame_err`=1.
- Dropped frames: 3 frame starts during COMPUTE → `frames_dropped`=3, `vsync_out` stays 1; `clear_err` → 0.
- Watchdog: `timeout_cycles`=64, only bits 0..2 pulse → `timeout_err`=1 after 64 COMPUTE cycles, `result` unchanged.
- Order and reset: bit 2 pulses before bit 1 → `frame_err`=1, inference still completes. Then `rst_n` asserted during CAPTURE → all outputs at reset values within the same cycle.
